// File: rtl/ofm_requant_pkg.sv
// Shared definitions for the output-feature-map requantiser: FSM encoding,
// default geometry and the clog2-derived widths used across the slice.
package ofm_requant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Never returns zero so single-entry tables still get a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CO         = 8;
  localparam int DEF_OFM_SIZE   = 64;
  localparam int DEF_FIFO_DEPTH = 16;

  localparam int CH_W  = clog2_min1(DEF_CO);
  localparam int PIX_W = clog2_min1(DEF_OFM_SIZE * DEF_OFM_SIZE);
  localparam int PTR_W = clog2_min1(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/ofm_requant_if.sv
// Output activation stream: show-ahead valid/ready with a channel tag.
interface ofm_requant_if #(
  parameter int OUT_WIDTH = 16,
  parameter int CH_W      = 3
);

  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic        [CH_W-1:0]      out_ch;

  modport master (output out_valid, output out_data, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ch, output out_ready);

endinterface

// File: rtl/ofm_fifo_sync.sv
// Single-clock show-ahead FIFO; head entry is visible on dout while not empty.
module ofm_fifo_sync
  import ofm_requant_pkg::*;
#(
  parameter int WIDTH    = 19,
  parameter int DEPTH    = DEF_FIFO_DEPTH,
  parameter int PTR_BITS = PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_BITS - 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra pointer MSB separates a full FIFO from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ofm_requant.sv
// Adds per-channel bias to CONV partial sums, rounds/shifts/saturates to the
// activation width, optionally applies ReLU, and buffers results in a FIFO.
module ofm_requant
  import ofm_requant_pkg::*;
#(
  parameter int DATA_WIDTH  = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int OFM_SIZE    = DEF_OFM_SIZE,
  parameter int CO          = DEF_CO,
  parameter int SHIFT_WIDTH = 6,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          bias_wr,
  input  logic [clog2_min1(CO)-1:0]     bias_idx,
  input  logic signed [DATA_WIDTH-1:0]  bias_in,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          relu_en,
  ofm_requant_if.master                 ofm,
  output logic                          busy,
  output logic                          layer_done,
  output logic                          overflow
);

  localparam int CW        = clog2_min1(CO);
  localparam int PIX_TOTAL = OFM_SIZE * OFM_SIZE;
  localparam int PW        = clog2_min1(PIX_TOTAL);
  localparam int SW        = DATA_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                       state, state_nxt;
  logic [PW-1:0]                pix_cnt;
  logic [CW-1:0]                ch_cnt;
  logic                         accept;
  logic                         last_in;
  logic signed [DATA_WIDTH-1:0] bias_mem [CO];

  logic                         s1_valid;
  logic signed [DATA_WIDTH:0]   s1_sum;
  logic [CW-1:0]                s1_ch;
  logic                         s2_valid;
  logic signed [OUT_WIDTH-1:0]  s2_data;
  logic [CW-1:0]                s2_ch;

  logic signed [SW-1:0]         rnd_add, rnd_sum, shifted;
  logic signed [OUT_WIDTH-1:0]  req_val;

  logic                         fifo_full, fifo_empty, fifo_pop;
  logic [OUT_WIDTH+CW-1:0]      fifo_dout;

  // An in_valid coinciding with start belongs to no layer and is dropped.
  assign accept  = (state == RUN) && in_valid && !start;
  assign last_in = accept && (pix_cnt == PW'(PIX_TOTAL - 1)) && (ch_cnt == CW'(CO - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (last_in) state_nxt = DRAIN;
        DRAIN:   if (!s1_valid && !s2_valid && fifo_empty) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else if (accept) begin
      if (pix_cnt == PW'(PIX_TOTAL - 1)) begin
        pix_cnt <= '0;
        ch_cnt  <= (ch_cnt == CW'(CO - 1)) ? '0 : ch_cnt + CW'(1);
      end else begin
        pix_cnt <= pix_cnt + PW'(1);
      end
    end
  end

  // The bias table survives start; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CO; i++) bias_mem[i] <= '0;
    end else if (bias_wr) begin
      bias_mem[bias_idx] <= bias_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_sum  <= {in_data[DATA_WIDTH-1], in_data} + {bias_mem[ch_cnt][DATA_WIDTH-1], bias_mem[ch_cnt]};
    s1_ch   <= ch_cnt;
    s2_data <= req_val;
    s2_ch   <= s1_ch;
  end

  // Round half up, arithmetic shift, saturate, then ReLU; two guard bits keep the rounding add from wrapping.
  always_comb begin
    rnd_add = '0;
    if (shift != '0) rnd_add = SW'(1) << (shift - SHIFT_WIDTH'(1));
    rnd_sum = {s1_sum[DATA_WIDTH], s1_sum} + rnd_add;
    shifted = rnd_sum >>> shift;
    if (shifted > SAT_MAX)      req_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) req_val = SAT_MIN[OUT_WIDTH-1:0];
    else                        req_val = shifted[OUT_WIDTH-1:0];
    if (relu_en && req_val[OUT_WIDTH-1]) req_val = '0;
  end

  assign fifo_pop = !fifo_empty && ofm.out_ready;

  ofm_fifo_sync #(
    .WIDTH    (OUT_WIDTH + CW),
    .DEPTH    (FIFO_DEPTH),
    .PTR_BITS (clog2_min1(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (s2_valid),
    .pop   (fifo_pop),
    .din   ({s2_ch, s2_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || start)                             overflow <= 1'b0;
    else if (s2_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  assign ofm.out_valid = !fifo_empty;
  assign ofm.out_data  = fifo_dout[OUT_WIDTH-1:0];
  assign ofm.out_ch    = fifo_dout[OUT_WIDTH+CW-1:OUT_WIDTH];
  assign busy          = (state == RUN) || (state == DRAIN);
  assign layer_done    = (state == DONE);

endmodule

// File: tb/tb_ofm_requant.sv
// Directed self-checking bench for ofm_requant on a small 4x4, 2-channel layer.
module tb_ofm_requant;

  localparam int DW    = 48;
  localparam int OW    = 16;
  localparam int OFM   = 4;
  localparam int NCO   = 2;
  localparam int SHW   = 6;
  localparam int DEPTH = 16;
  localparam int CW    = 1;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid, bias_wr, relu_en;
  logic signed [DW-1:0] in_data, bias_in;
  logic [CW-1:0]        bias_idx;
  logic [SHW-1:0]       shift;
  logic                 busy, layer_done, overflow;

  int errors = 0;
  int checks = 0;
  int outIdx = 0;
  int doneCnt = 0;

  ofm_requant_if #(.OUT_WIDTH(OW), .CH_W(CW)) ofm_bus ();

  ofm_requant #(
    .DATA_WIDTH  (DW),
    .OUT_WIDTH   (OW),
    .OFM_SIZE    (OFM),
    .CO          (NCO),
    .SHIFT_WIDTH (SHW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .bias_wr    (bias_wr),
    .bias_idx   (bias_idx),
    .bias_in    (bias_in),
    .shift      (shift),
    .relu_en    (relu_en),
    .ofm        (ofm_bus),
    .busy       (busy),
    .layer_done (layer_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic signed [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expects out_ready=1 so the single result is popped after being checked.
  task automatic sendAndCheck(input string tag, input logic signed [DW-1:0] d,
                              input int expData, input int expCh);
    applyStimulus(d);
    tick();
    tick();
    checkOutput({tag, "_valid"}, ofm_bus.out_valid, 1);
    checkOutput({tag, "_data"}, ofm_bus.out_data, expData);
    checkOutput({tag, "_ch"}, ofm_bus.out_ch, expCh);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    bias_wr = 1'b0; bias_idx = '0; bias_in = '0; shift = '0; relu_en = 1'b0;
    ofm_bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_out_valid", ofm_bus.out_valid, 0);
    checkOutput("rst_out_data", ofm_bus.out_data, 0);
    checkOutput("rst_out_ch", ofm_bus.out_ch, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_layer_done", layer_done, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;

    $display("[TB] bias and rounding");
    bias_wr = 1'b1; bias_idx = 1'b0; bias_in = 100;
    tick();
    bias_idx = 1'b1; bias_in = -50;
    tick();
    bias_wr = 1'b0;
    shift = 6'd4;
    pulseStart();
    checkOutput("run_busy", busy, 1);
    applyStimulus(1000);
    checkOutput("lat1_valid", ofm_bus.out_valid, 0);
    tick();
    checkOutput("lat2_valid", ofm_bus.out_valid, 0);
    tick();
    checkOutput("lat3_valid", ofm_bus.out_valid, 1);
    checkOutput("round_data", ofm_bus.out_data, 69);
    checkOutput("round_ch", ofm_bus.out_ch, 0);
    ofm_bus.out_ready = 1'b1;
    tick();
    checkOutput("pop_empty", ofm_bus.out_valid, 0);

    $display("[TB] saturation and relu");
    shift = '0;
    pulseStart();
    sendAndCheck("sat_pos", 48'sh0100_0000_0000, 32767, 0);
    sendAndCheck("sat_neg", -48'sh0100_0000_0000, -32768, 0);
    relu_en = 1'b1;
    sendAndCheck("relu_neg", -48'sh0100_0000_0000, 0, 0);
    relu_en = 1'b0;

    $display("[TB] full layer");
    pulseStart();
    for (int k = 0; k < 45; k++) begin
      in_valid = (k < 32);
      in_data  = DW'(k);
      tick();
      if (ofm_bus.out_valid === 1'b1) begin
        checkOutput("layer_data", ofm_bus.out_data, (outIdx < 16) ? outIdx + 100 : outIdx - 50);
        checkOutput("layer_ch", ofm_bus.out_ch, (outIdx < 16) ? 0 : 1);
        outIdx++;
      end
      if (layer_done === 1'b1) doneCnt++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput("layer_count", outIdx, 32);
    checkOutput("layer_done_pulses", doneCnt, 1);
    checkOutput("layer_busy_after", busy, 0);
    applyStimulus(55);
    tick();
    tick();
    tick();
    checkOutput("idle_ignored", ofm_bus.out_valid, 0);

    $display("[TB] backpressure");
    ofm_bus.out_ready = 1'b0;
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(i * 10));
    tick();
    tick();
    tick();
    checkOutput("bp_valid", ofm_bus.out_valid, 1);
    checkOutput("bp_head", ofm_bus.out_data, 100);
    checkOutput("bp_no_ovf", overflow, 0);
    tick();
    tick();
    checkOutput("bp_stable_data", ofm_bus.out_data, 100);
    checkOutput("bp_stable_ch", ofm_bus.out_ch, 0);
    applyStimulus(7);
    tick();
    tick();
    tick();
    checkOutput("bp_ovf_set", overflow, 1);
    checkOutput("bp_head_kept", ofm_bus.out_data, 100);
    ofm_bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("bp_drain_valid", ofm_bus.out_valid, 1);
      checkOutput("bp_drain_data", ofm_bus.out_data, i * 10 + 100);
      tick();
    end
    checkOutput("bp_drained", ofm_bus.out_valid, 0);

    $display("[TB] full with simultaneous push and pop");
    ofm_bus.out_ready = 1'b0;
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(DW'(i));
    tick();
    tick();
    tick();
    checkOutput("pp_full_no_ovf", overflow, 0);
    applyStimulus(5);
    tick();
    ofm_bus.out_ready = 1'b1;
    tick();
    ofm_bus.out_ready = 1'b0;
    checkOutput("pp_no_ovf", overflow, 0);
    checkOutput("pp_head", ofm_bus.out_data, 101);
    ofm_bus.out_ready = 1'b1;
    for (int j = 0; j < 15; j++) begin
      checkOutput("pp_drain_data", ofm_bus.out_data, j + 101);
      tick();
    end
    checkOutput("pp_tail_data", ofm_bus.out_data, -45);
    checkOutput("pp_tail_ch", ofm_bus.out_ch, 1);
    tick();
    checkOutput("pp_drained", ofm_bus.out_valid, 0);

    $display("[TB] restart and reset");
    ofm_bus.out_ready = 1'b0;
    applyStimulus(0);
    applyStimulus(0);
    tick();
    tick();
    tick();
    checkOutput("rs_pending", ofm_bus.out_valid, 1);
    start = 1'b1; in_valid = 1'b1; in_data = 999;
    tick();
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    checkOutput("rs_flushed", ofm_bus.out_valid, 0);
    checkOutput("rs_busy", busy, 1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("rs_start_input_dropped", ofm_bus.out_valid, 0);
    ofm_bus.out_ready = 1'b1;
    sendAndCheck("rs_restart", 0, 100, 0);
    ofm_bus.out_ready = 1'b0;
    for (int i = 0; i < 31; i++) applyStimulus(DW'(i));
    tick();
    tick();
    tick();
    checkOutput("drain_busy", busy, 1);
    checkOutput("drain_ovf", overflow, 1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_out_valid", ofm_bus.out_valid, 0);
    checkOutput("mid_rst_out_data", ofm_bus.out_data, 0);
    checkOutput("mid_rst_out_ch", ofm_bus.out_ch, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_layer_done", layer_done, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    rst = 1'b0;
    pulseStart();
    ofm_bus.out_ready = 1'b1;
    sendAndCheck("bias_cleared", 1000, 1000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ofm_requant.md
OFM_REQUANT -- requirements
Module: ofm_requant

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 48, input partial-sum width.
- OUT_WIDTH, 16, output activation width.
- OFM_SIZE, 64, output feature-map side length (pixels per channel = OFM_SIZE*OFM_SIZE).
- CO, 8, output channels per layer.
- SHIFT_WIDTH, 6, requant shift field width.
- FIFO_DEPTH, 16, output FIFO entries (power of 2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle layer start; flushes and re-arms.
- in_valid, in, 1, CONV result valid (driven from CONV out_valid).
- in_data, in, DATA_WIDTH, signed CONV result.
- bias_wr, in, 1, bias table write strobe.
- bias_idx, in, clog2(CO), bias table index.
- bias_in, in, DATA_WIDTH, signed bias value.
- shift, in, SHIFT_WIDTH, right-shift amount, static during a layer.
- relu_en, in, 1, clamp negative results to 0.
- out_valid, out, 1, out_data/out_ch valid.
- out_ready, in, 1, consumer accepts.
- out_data, out, OUT_WIDTH, signed requantised activation.
- out_ch, out, clog2(CO), channel of out_data.
- busy, out, 1, high in RUN or DRAIN.
- layer_done, out, 1, one-cycle pulse at layer completion.
- overflow, out, 1, sticky; an input was dropped because the FIFO was full.
REQ-003 Clocking and reset SHALL be one clock (clk) with synchronous, active-high reset (rst).

Function
REQ-004 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN when the last input (pixel OFM_SIZE^2-1 of channel CO-1) is accepted.
- DRAIN -> DONE when both pipeline stages and the FIFO are empty.
- DONE -> IDLE unconditionally; layer_done=1 only in DONE.
REQ-005 in_valid SHALL be accepted only in RUN; in IDLE, DRAIN and DONE it SHALL be ignored with no state change.
REQ-006 Counters pix_cnt (0..OFM_SIZE^2-1) and ch_cnt (0..CO-1) SHALL advance per accepted input.
- pix_cnt wraps to 0 and increments ch_cnt.
- The ch_cnt value at acceptance travels with the datum as its channel tag.
REQ-007 Stage 1 (registered) SHALL compute sum = sext(in_data) + sext(bias[ch_cnt]) at DATA_WIDTH+1 bits, with no wrap.
REQ-008 Stage 2 (registered) SHALL compute the requantised value:
- If shift>0, add 2^(shift-1), then arithmetic right shift by shift; if shift=0, pass through.
- Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Then, if relu_en, replace negatives with 0.
REQ-009 The stage 2 result and its tag SHALL be pushed into the FIFO the cycle after stage 2 is valid.
REQ-010 Latency SHALL be 3 cycles: in_valid at cycle N gives out_valid at N+3 when the FIFO is empty.
REQ-011 The FIFO SHALL be show-ahead; out_data/out_ch are driven from the head entry, and a pop occurs when out_valid && out_ready.
REQ-012 FIFO boundary conditions:
- Full with no pop: the push is dropped and overflow is set.
- Full with a simultaneous pop: the push succeeds.
- Empty with a simultaneous push: out_valid rises the next cycle, with no bypass.
REQ-013 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra MSB distinguishing full from empty.
REQ-014 A bias_wr SHALL be accepted in any state and take effect from the next cycle; in_valid and bias_wr on the same cycle uses the old bias.
REQ-015 start in any state SHALL behave as follows:
- Clear counters, pipeline valids, FIFO pointers and overflow; keep the bias table.
- Enter RUN.
- An in_valid on the same cycle is dropped.
REQ-016 out_data and out_ch SHALL be held stable while out_valid && !out_ready.

Reset
REQ-017 On rst the block SHALL:
- Enter IDLE.
- Clear counters, pipeline valids, FIFO pointers and the bias table.
- Drive out_valid=0, out_data=0, out_ch=0, busy=0, layer_done=0, overflow=0.
REQ-018 rst SHALL take priority over start, bias_wr and in_valid; rst mid-layer discards all in-flight data.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding and clog2-derived widths (CH_W, PIX_W, PTR_W).
REQ-020 The FIFO SHALL be one sub-module, ofm_fifo_sync (single-clock, show-ahead, full/empty flags); all other logic is inline.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Bias and rounding: bias[0]=100, shift=4, relu_en=0, in_data=1000 -> out_data=69, out_ch=0, out_valid 3 cycles after in_valid.
- Saturation and ReLU: in_data=2^40, shift=0 -> 32767; in_data=-2^40, relu_en=0 -> -32768; with relu_en=1 -> 0.
- Full layer: OFM_SIZE=4, CO=2, 32 inputs, out_ready=1 -> 32 outputs, out_ch 0 for the first 16 and 1 for the next 16, one layer_done pulse, busy low after.
- Backpressure: out_ready=0 and 16 inputs -> out_valid held with stable data and overflow=0; the 17th input sets overflow; releasing out_ready returns the first 16 in order.
- Full with simultaneous push and pop: FIFO full, out_ready=1 and in_valid on the same cycle -> no drop, overflow stays 0.
- Restart and reset: start mid-RUN -> pointers clear, counters restart at 0, bias retained; rst mid-DRAIN -> all outputs 0 next cycle, bias reads 0.
